// File: rtl/ws2812_pkg.sv
// Shared widths, default timing constants and FSM encoding for the WS2812 frame path.
package ws2812_pkg;
  localparam int PIX_W           = 6;
  localparam int DATA_W          = 24;
  localparam int LATCH_CYC_DEF   = 15000;
  localparam int TIMEOUT_CYC_DEF = 2000000;

  typedef enum logic [1:0] {IDLE, START, STREAM, LATCH} state_t;
endpackage

// File: rtl/ws2812_arb_pick.sv
// Combinational grant picker: the mode-preferred requester if it is pending,
// otherwise the lowest pending index.
module ws2812_arb_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         mode,
  output logic [1:0]         grant,
  output logic               valid
);
  always_comb begin
    grant = 2'd0;
    valid = |pending;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) grant = i[1:0];
    end
    if (mode == 2'b00 && pending[0]) grant = 2'd0;
    else if (mode == 2'b10 && pending[1]) grant = 2'd1;
  end
endmodule

// File: rtl/ws2812_arbiter.sv
// Grants the shared ws2812_ctrl to one requester for a whole frame, routes pixel
// fetches to the owner, enforces the latch gap and aborts stalled frames.
module ws2812_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LED_NUM     = 64,
  parameter int LATCH_CYC   = LATCH_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [1:0]                mode,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*PIX_W-1:0]  req_cfg_num,
  input  logic [NUM_REQ*DATA_W-1:0] req_cfg_data,
  output logic [NUM_REQ-1:0]        req_cfg_start,
  output logic [NUM_REQ-1:0]        req_done,
  input  logic                      ctrl_cfg_start,
  output logic                      ctrl_start,
  output logic [PIX_W-1:0]          ctrl_cfg_num,
  output logic [DATA_W-1:0]         ctrl_cfg_data,
  output logic                      busy,
  output logic [1:0]                owner,
  output logic                      timeout_err
);
  localparam int PIX_CW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int LAT_CW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
  localparam int WD_CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PIX_CW-1:0] PIX_LAST = PIX_CW'(LED_NUM - 1);
  localparam logic [LAT_CW-1:0] LAT_LAST = LAT_CW'(LATCH_CYC - 1);
  localparam logic [WD_CW-1:0]  WD_LAST  = WD_CW'(TIMEOUT_CYC - 1);

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  pending, grant_oh;
  logic [1:0]          pick_grant;
  logic                pick_vld, grant_now;
  logic [PIX_CW-1:0]   pix_cnt;
  logic [LAT_CW-1:0]   lat_cnt;
  logic [WD_CW-1:0]    wd_cnt;
  logic                last_pix, done_pulse;

  ws2812_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (pending),
    .mode    (mode),
    .grant   (pick_grant),
    .valid   (pick_vld)
  );

  assign grant_now = (state == IDLE) && pick_vld;
  assign grant_oh  = NUM_REQ'(1) << pick_grant;
  assign last_pix  = ctrl_cfg_start && (pix_cnt == PIX_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // A completed frame takes priority over a watchdog hit in the same cycle.
  always_comb begin
    state_nxt   = state;
    ctrl_start  = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    done_pulse  = 1'b0;
    case (state)
      IDLE:   if (pick_vld) state_nxt = START;
      START: begin
        busy       = 1'b1;
        ctrl_start = 1'b1;
        state_nxt  = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (last_pix) begin
          state_nxt = LATCH;
        end else if (wd_cnt == WD_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      LATCH: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) begin
          done_pulse = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_cfg_start = '0;
    req_done      = '0;
    ctrl_cfg_num  = '0;
    ctrl_cfg_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == i[1:0]) begin
        req_cfg_start[i] = (state == STREAM) && ctrl_cfg_start;
        req_done[i]      = done_pulse;
        if (busy) begin
          ctrl_cfg_num  = req_cfg_num[PIX_W*i +: PIX_W];
          ctrl_cfg_data = req_cfg_data[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= '0;
      owner   <= 2'd0;
      pix_cnt <= '0;
      lat_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      pending <= (pending & ~(grant_now ? grant_oh : '0)) | req_start;
      if (grant_now) owner <= pick_grant;

      if (state == START)                                      pix_cnt <= '0;
      else if (state == STREAM && ctrl_cfg_start && !last_pix) pix_cnt <= pix_cnt + 1'b1;

      if (state == START)       wd_cnt <= '0;
      else if (state == STREAM) wd_cnt <= wd_cnt + 1'b1;

      if (state == LATCH) lat_cnt <= lat_cnt + 1'b1;
      else                lat_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_ws2812_arbiter.sv
// Directed-vector bench for ws2812_arbiter with LED_NUM=4, LATCH_CYC=8, TIMEOUT_CYC=100.
module tb_ws2812_arbiter;
  localparam int NR = 2;
  localparam int LN = 4;
  localparam int LC = 8;
  localparam int TO = 100;
  localparam logic [23:0] D0 = 24'hA1A2A3;
  localparam logic [23:0] D1 = 24'hB1B2B3;
  localparam logic [5:0]  N0 = 6'd11;
  localparam logic [5:0]  N1 = 6'd22;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [NR-1:0]  req_start = '0;
  logic [NR*6-1:0]  req_cfg_num;
  logic [NR*24-1:0] req_cfg_data;
  logic [NR-1:0]  req_cfg_start, req_done;
  logic           ctrl_cfg_start = 1'b0;
  logic           ctrl_start, busy, timeout_err;
  logic [5:0]     ctrl_cfg_num;
  logic [23:0]    ctrl_cfg_data;
  logic [1:0]     owner;

  int vecs = 0;
  int errs = 0;

  assign req_cfg_num  = {N1, N0};
  assign req_cfg_data = {D1, D0};

  always #5 sys_clk = ~sys_clk;

  ws2812_arbiter #(.NUM_REQ(NR), .LED_NUM(LN), .LATCH_CYC(LC), .TIMEOUT_CYC(TO)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .mode           (mode),
    .req_start      (req_start),
    .req_cfg_num    (req_cfg_num),
    .req_cfg_data   (req_cfg_data),
    .req_cfg_start  (req_cfg_start),
    .req_done       (req_done),
    .ctrl_cfg_start (ctrl_cfg_start),
    .ctrl_start     (ctrl_start),
    .ctrl_cfg_num   (ctrl_cfg_num),
    .ctrl_cfg_data  (ctrl_cfg_data),
    .busy           (busy),
    .owner          (owner),
    .timeout_err    (timeout_err)
  );

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns cycles waited until ctrl_start is seen (-1 if never); leaves time in that cycle.
  task automatic wait_start(output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (ctrl_start) begin
        n = i;
        return;
      end
      nxt();
    end
  endtask

  task automatic drive_pix(input int n, output logic [1:0] seen, output logic [23:0] dat,
                           output logic [5:0] num);
    seen = '0;
    dat  = '0;
    num  = '0;
    for (int k = 0; k < n; k++) begin
      ctrl_cfg_start = 1'b1;
      @(negedge sys_clk);
      seen = seen | req_cfg_start;
      dat  = ctrl_cfg_data;
      num  = ctrl_cfg_num;
      nxt();
    end
    ctrl_cfg_start = 1'b0;
  endtask

  // Cycle index (1 = first cycle after the last pixel) of the req_done pulse, -1 if none.
  task automatic wait_done(output int n, output logic [1:0] d);
    n = -1;
    d = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sys_clk);
      if (req_done != '0) begin
        n = i;
        d = req_done;
        nxt();
        return;
      end
      nxt();
    end
  endtask

  task automatic test_reset();
    req_start = 2'b11;
    ctrl_cfg_start = 1'b1;
    @(negedge sys_clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (owner !== 2'd0) begin errs++; $display("FAIL reset_owner: got %0d want 0", owner); end
    vecs++; if (ctrl_start !== 1'b0) begin errs++; $display("FAIL reset_ctrl_start: got %b want 0", ctrl_start); end
    vecs++; if (req_cfg_start !== 2'b00) begin errs++; $display("FAIL reset_req_cfg_start: got %b want 00", req_cfg_start); end
    vecs++; if (req_done !== 2'b00) begin errs++; $display("FAIL reset_req_done: got %b want 00", req_done); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    vecs++; if (ctrl_cfg_data !== 24'h0) begin errs++; $display("FAIL reset_data: got %h want 0", ctrl_cfg_data); end
    vecs++; if (ctrl_cfg_num !== 6'h0) begin errs++; $display("FAIL reset_num: got %h want 0", ctrl_cfg_num); end
    nxt();
    req_start = '0;
    ctrl_cfg_start = 1'b0;
    sys_rst_n = 1'b1;
    nxt();
    @(negedge sys_clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_no_pending: got busy %b want 0", busy); end
    nxt();
  endtask

  task automatic test_single();
    mode = 2'b10;
    req_start = 2'b10;
    @(negedge sys_clk);
    vecs++; if (ctrl_start !== 1'b0) begin errs++; $display("FAIL single_t0_start: got %b want 0", ctrl_start); end
    nxt();
    req_start = '0;
    @(negedge sys_clk);
    vecs++; if ({ctrl_start, busy} !== 2'b00) begin errs++; $display("FAIL single_t1: got start,busy %b want 00", {ctrl_start, busy}); end
    nxt();
    @(negedge sys_clk);
    vecs++; if (ctrl_start !== 1'b1) begin errs++; $display("FAIL single_t2_start: got %b want 1", ctrl_start); end
    vecs++; if (owner !== 2'd1) begin errs++; $display("FAIL single_owner: got %0d want 1", owner); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", busy); end
    nxt();
    for (int k = 0; k < LN; k++) begin
      ctrl_cfg_start = 1'b0;
      @(negedge sys_clk);
      vecs++; if (req_cfg_start !== 2'b00) begin errs++; $display("FAIL single_gap%0d: got %b want 00", k, req_cfg_start); end
      vecs++; if (ctrl_cfg_data !== D1) begin errs++; $display("FAIL single_data%0d: got %h want %h", k, ctrl_cfg_data, D1); end
      vecs++; if (ctrl_cfg_num !== N1) begin errs++; $display("FAIL single_num%0d: got %0d want %0d", k, ctrl_cfg_num, N1); end
      nxt();
      ctrl_cfg_start = 1'b1;
      @(negedge sys_clk);
      vecs++; if (req_cfg_start !== 2'b10) begin errs++; $display("FAIL single_pix%0d: got %b want 10", k, req_cfg_start); end
      nxt();
    end
    for (int j = 1; j <= LC; j++) begin
      @(negedge sys_clk);
      vecs++; if (req_cfg_start !== 2'b00) begin errs++; $display("FAIL single_latch_drop%0d: got %b want 00", j, req_cfg_start); end
      vecs++; if (req_done !== ((j == LC) ? 2'b10 : 2'b00)) begin errs++; $display("FAIL single_done%0d: got %b want %b", j, req_done, (j == LC) ? 2'b10 : 2'b00); end
      nxt();
    end
    ctrl_cfg_start = 1'b0;
    @(negedge sys_clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    vecs++; if (ctrl_cfg_data !== 24'h0) begin errs++; $display("FAIL single_idle_data: got %h want 0", ctrl_cfg_data); end
    vecs++; if (owner !== 2'd1) begin errs++; $display("FAIL single_last_owner: got %0d want 1", owner); end
    nxt();
  endtask

  task automatic test_simultaneous();
    int n;
    logic [1:0] seen, d;
    logic [23:0] dat;
    logic [5:0] num;
    mode = 2'b10;
    req_start = 2'b11;
    nxt();
    req_start = '0;
    wait_start(n);
    vecs++; if (n !== 1) begin errs++; $display("FAIL simul_start1: got %0d want 1", n); end
    vecs++; if (owner !== 2'd1) begin errs++; $display("FAIL simul_owner1: got %0d want 1", owner); end
    nxt();
    drive_pix(LN, seen, dat, num);
    vecs++; if (seen !== 2'b10) begin errs++; $display("FAIL simul_route1: got %b want 10", seen); end
    vecs++; if (dat !== D1) begin errs++; $display("FAIL simul_data1: got %h want %h", dat, D1); end
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b10) begin errs++; $display("FAIL simul_done1: got %0d/%b want %0d/10", n, d, LC); end
    wait_start(n);
    vecs++; if (n !== 1) begin errs++; $display("FAIL simul_spacing: got %0d want 1", n); end
    vecs++; if (owner !== 2'd0) begin errs++; $display("FAIL simul_owner0: got %0d want 0", owner); end
    nxt();
    drive_pix(LN, seen, dat, num);
    vecs++; if (seen !== 2'b01) begin errs++; $display("FAIL simul_route0: got %b want 01", seen); end
    vecs++; if (dat !== D0 || num !== N0) begin errs++; $display("FAIL simul_data0: got %h/%0d want %h/%0d", dat, num, D0, N0); end
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b01) begin errs++; $display("FAIL simul_done0: got %0d/%b want %0d/01", n, d, LC); end
  endtask

  task automatic test_mode_flip();
    int n;
    logic [1:0] seen, d;
    logic [23:0] dat;
    logic [5:0] num;
    mode = 2'b00;
    req_start = 2'b01;
    nxt();
    req_start = '0;
    wait_start(n);
    vecs++; if (n !== 1 || owner !== 2'd0) begin errs++; $display("FAIL flip_start: got %0d/owner %0d want 1/0", n, owner); end
    nxt();
    drive_pix(2, seen, dat, num);
    mode = 2'b10;
    req_start = 2'b10;
    @(negedge sys_clk);
    vecs++; if (owner !== 2'd0) begin errs++; $display("FAIL flip_owner_mid: got %0d want 0", owner); end
    nxt();
    req_start = '0;
    drive_pix(2, seen, dat, num);
    vecs++; if (seen !== 2'b01) begin errs++; $display("FAIL flip_route: got %b want 01", seen); end
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b01) begin errs++; $display("FAIL flip_done0: got %0d/%b want %0d/01", n, d, LC); end
    wait_start(n);
    vecs++; if (n !== 1 || owner !== 2'd1) begin errs++; $display("FAIL flip_next: got %0d/owner %0d want 1/1", n, owner); end
    nxt();
    drive_pix(LN, seen, dat, num);
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b10) begin errs++; $display("FAIL flip_done1: got %0d/%b want %0d/10", n, d, LC); end
  endtask

  task automatic test_rerequest();
    int n;
    logic [1:0] seen, d;
    logic [23:0] dat;
    logic [5:0] num;
    mode = 2'b01;
    req_start = 2'b01;
    nxt();
    req_start = '0;
    wait_start(n);
    nxt();
    drive_pix(2, seen, dat, num);
    req_start = 2'b01;
    nxt();
    req_start = '0;
    drive_pix(2, seen, dat, num);
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b01) begin errs++; $display("FAIL rereq_done1: got %0d/%b want %0d/01", n, d, LC); end
    wait_start(n);
    vecs++; if (n !== 1 || owner !== 2'd0) begin errs++; $display("FAIL rereq_second: got %0d/owner %0d want 1/0", n, owner); end
    nxt();
    drive_pix(LN, seen, dat, num);
    vecs++; if (seen !== 2'b01) begin errs++; $display("FAIL rereq_route: got %b want 01", seen); end
    wait_done(n, d);
    vecs++; if (n !== LC || d !== 2'b01) begin errs++; $display("FAIL rereq_done2: got %0d/%b want %0d/01", n, d, LC); end
  endtask

  task automatic test_watchdog();
    int n;
    int hit = -1;
    logic saw_done = 1'b0;
    mode = 2'b01;
    req_start = 2'b10;
    nxt();
    req_start = '0;
    wait_start(n);
    nxt();
    for (int k = 1; k <= TO; k++) begin
      @(negedge sys_clk);
      if (timeout_err && hit < 0) hit = k;
      if (req_done != '0) saw_done = 1'b1;
      nxt();
    end
    @(negedge sys_clk);
    vecs++; if (hit !== TO) begin errs++; $display("FAIL wd_cycle: got %0d want %0d", hit, TO); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wd_busy: got %b want 0", busy); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL wd_pulse_len: got %b want 0", timeout_err); end
    vecs++; if (saw_done !== 1'b0) begin errs++; $display("FAIL wd_no_done: got %b want 0", saw_done); end
    nxt();
  endtask

  task automatic test_reset_midstream();
    int n;
    logic flag = 1'b0;
    logic [1:0] seen;
    logic [23:0] dat;
    logic [5:0] num;
    mode = 2'b10;
    req_start = 2'b10;
    nxt();
    req_start = '0;
    wait_start(n);
    nxt();
    drive_pix(2, seen, dat, num);
    req_start = 2'b01;
    nxt();
    req_start = '0;
    ctrl_cfg_start = 1'b1;
    #1;
    sys_rst_n = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vecs++; if (owner !== 2'd0) begin errs++; $display("FAIL rst_mid_owner: got %0d want 0", owner); end
    vecs++; if (req_cfg_start !== 2'b00) begin errs++; $display("FAIL rst_mid_route: got %b want 00", req_cfg_start); end
    vecs++; if (ctrl_cfg_data !== 24'h0) begin errs++; $display("FAIL rst_mid_data: got %h want 0", ctrl_cfg_data); end
    ctrl_cfg_start = 1'b0;
    nxt();
    nxt();
    sys_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (ctrl_start || busy || req_done != '0) flag = 1'b1;
      nxt();
    end
    vecs++; if (flag !== 1'b0) begin errs++; $display("FAIL rst_mid_pending: got activity %b want 0", flag); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    nxt();
    nxt();
    test_reset();
    test_single();
    test_simultaneous();
    test_mode_flip();
    test_rerequest();
    test_watchdog();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
